// File: rtl/health_bar_renderer_pkg.sv
// fence_display_pkg: shared display constants and types for the health-bar
// sprite path.
//   - colour constants used by the bar renderer
//   - raster counter widths and screen extent
//   - hb_state_t: per-player health FSM state
package fence_display_pkg;

    localparam logic [23:0] WHITE      = 24'hFFFFFF;
    localparam logic [23:0] DRAIN_RED  = 24'hC00000;
    localparam logic [23:0] BAR_BG     = 24'h202020;
    localparam logic [23:0] FILL_GREEN = 24'h00C000;

    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;
    localparam int SCREEN_W = 1280;
    localparam int SCREEN_H = 720;
    localparam int HEALTH_W = 7;

    typedef enum logic [1:0] {
        ALIVE = 2'd0,
        HIT   = 2'd1,
        DEAD  = 2'd2
    } hb_state_t;

endpackage

// File: rtl/health_bar_renderer_if.sv
// health_bar_if: raster position, game events and bar outputs for one
// health-bar instance.
//   hcount_in/vcount_in   raster position
//   new_frame_in          pulse at start of vertical blank
//   game_reset_in         synchronous restart to full health
//   damage_valid_in/damage_amount_in  damage strobe and points
//   health_out/dead_out/pixel_out     bar state and 24-bit pixel (0 = transparent)
// master drives the raster/events, slave is the renderer.
interface health_bar_if;
    import fence_display_pkg::*;

    logic [HCOUNT_W-1:0] hcount_in;
    logic [VCOUNT_W-1:0] vcount_in;
    logic                new_frame_in;
    logic                game_reset_in;
    logic                damage_valid_in;
    logic [HEALTH_W-1:0] damage_amount_in;
    logic [HEALTH_W-1:0] health_out;
    logic                dead_out;
    logic [23:0]         pixel_out;

    modport master (
        output hcount_in, vcount_in, new_frame_in, game_reset_in,
               damage_valid_in, damage_amount_in,
        input  health_out, dead_out, pixel_out
    );

    modport slave (
        input  hcount_in, vcount_in, new_frame_in, game_reset_in,
               damage_valid_in, damage_amount_in,
        output health_out, dead_out, pixel_out
    );

endinterface

// File: rtl/health_bar_renderer_tracker.sv
// health_tracker: authoritative health, trailing ghost value, hit-flash timer
// and ALIVE/HIT/DEAD state for one player.
//   clk, rst_n       clock, async active-low reset
//   new_frame        frame tick (ghost drain, flash countdown)
//   game_reset       synchronous restart, wins over damage
//   damage_valid/damage_amount  damage strobe
//   health, ghost    current and trailing health
//   flash_on         fill should be drawn white this frame
//   dead             health has reached zero
module health_tracker
    import fence_display_pkg::*;
#(
    parameter int MAX_HEALTH   = 100,
    parameter int FLASH_FRAMES = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                new_frame,
    input  logic                game_reset,
    input  logic                damage_valid,
    input  logic [HEALTH_W-1:0] damage_amount,
    output logic [HEALTH_W-1:0] health,
    output logic [HEALTH_W-1:0] ghost,
    output logic                flash_on,
    output logic                dead
);

    // At least 3 bits so the blink bit [2] always exists.
    localparam int FW = ($clog2(FLASH_FRAMES + 1) < 3) ? 3 : $clog2(FLASH_FRAMES + 1);
    localparam logic [HEALTH_W-1:0] MAX_H   = HEALTH_W'(MAX_HEALTH);
    localparam logic [FW-1:0]       FLASH_N = FW'(FLASH_FRAMES);

    hb_state_t           state;
    logic [FW-1:0]       flash_cnt;
    logic [HEALTH_W-1:0] dmg_res;

    // Saturating subtract: never wraps below zero.
    assign dmg_res = (damage_amount >= health) ? '0 : health - damage_amount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            health    <= MAX_H;
            ghost     <= MAX_H;
            flash_cnt <= '0;
            state     <= ALIVE;
        end else if (game_reset) begin
            health    <= MAX_H;
            ghost     <= MAX_H;
            flash_cnt <= '0;
            state     <= ALIVE;
        end else begin
            // Ghost compares against pre-damage health, so a same-cycle hit
            // never pulls it down; it only drains one point per frame.
            if (new_frame)
                ghost <= (ghost > health) ? ghost - 1'b1 : health;

            case (state)
                ALIVE, HIT: begin
                    if (damage_valid) begin
                        health <= dmg_res;
                        if (dmg_res == '0) begin
                            state     <= DEAD;
                            flash_cnt <= '0;
                        end else begin
                            state     <= HIT;
                            flash_cnt <= FLASH_N;
                        end
                    end else if (state == HIT && new_frame) begin
                        if (flash_cnt <= FW'(1)) begin
                            flash_cnt <= '0;
                            state     <= ALIVE;
                        end else begin
                            flash_cnt <= flash_cnt - 1'b1;
                        end
                    end
                end
                DEAD:    flash_cnt <= '0;
                default: state <= ALIVE;
            endcase
        end
    end

    // Bit 2 of the countdown gives a 4-on/4-off blink.
    assign flash_on = (state == HIT) && flash_cnt[2];
    assign dead     = (state == DEAD);

endmodule

// File: rtl/health_bar_renderer.sv
// health_bar_renderer: per-player health-bar sprite. Tracks health via
// health_tracker and renders a bordered bar with fill, ghost drain and hit
// flash through a fixed 2-cycle pixel pipeline.
//   clk_in, rst_n_in  pixel clock, async active-low reset
//   bus (slave)       raster position, game events, health/dead/pixel outputs
module health_bar_renderer
    import fence_display_pkg::*;
#(
    parameter int          MAX_HEALTH     = 100,
    parameter int          PX_PER_HP_LOG2 = 1,
    parameter int          BAR_X          = 32,
    parameter int          BAR_Y          = 24,
    parameter int          BAR_H          = 16,
    parameter int          FLASH_FRAMES   = 24,
    parameter logic [23:0] FILL_COLOR     = 24'h00C000
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    health_bar_if.slave bus
);

    localparam int BAR_W = MAX_HEALTH << PX_PER_HP_LOG2;

    // Interior spans [X_LO, X_HI) x [Y_LO, Y_HI); the border ring sits one
    // pixel outside on every side.
    localparam logic [HCOUNT_W-1:0] X_LO = HCOUNT_W'(BAR_X);
    localparam logic [HCOUNT_W-1:0] X_HI = HCOUNT_W'(BAR_X + BAR_W);
    localparam logic [VCOUNT_W-1:0] Y_LO = VCOUNT_W'(BAR_Y);
    localparam logic [VCOUNT_W-1:0] Y_HI = VCOUNT_W'(BAR_Y + BAR_H);

    logic [HEALTH_W-1:0] health;
    logic [HEALTH_W-1:0] ghost;
    logic                flash_on;
    logic                dead;

    health_tracker #(
        .MAX_HEALTH   (MAX_HEALTH),
        .FLASH_FRAMES (FLASH_FRAMES)
    ) u_tracker (
        .clk           (clk_in),
        .rst_n         (rst_n_in),
        .new_frame     (bus.new_frame_in),
        .game_reset    (bus.game_reset_in),
        .damage_valid  (bus.damage_valid_in),
        .damage_amount (bus.damage_amount_in),
        .health        (health),
        .ghost         (ghost),
        .flash_on      (flash_on),
        .dead          (dead)
    );

    // Stage 1 decode.
    logic                h_in, v_in, h_ring, v_ring;
    logic [HCOUNT_W-1:0] h_plus1;
    logic [VCOUNT_W-1:0] v_plus1;

    // +1 form keeps the left/top ring test free of underflow.
    assign h_plus1 = bus.hcount_in + 1'b1;
    assign v_plus1 = bus.vcount_in + 1'b1;
    assign h_in    = (bus.hcount_in >= X_LO) && (bus.hcount_in < X_HI);
    assign v_in    = (bus.vcount_in >= Y_LO) && (bus.vcount_in < Y_HI);
    assign h_ring  = (h_plus1 >= X_LO) && (bus.hcount_in <= X_HI);
    assign v_ring  = (v_plus1 >= Y_LO) && (bus.vcount_in <= Y_HI);

    logic [HCOUNT_W-1:0] s1_hcount;
    logic                s1_in_bar_x, s1_in_bar_y, s1_border, s1_flash;
    logic [HCOUNT_W-1:0] s1_fill_edge, s1_ghost_edge;
    logic [23:0]         pixel;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_hcount     <= '0;
            s1_in_bar_x   <= 1'b0;
            s1_in_bar_y   <= 1'b0;
            s1_border     <= 1'b0;
            s1_flash      <= 1'b0;
            s1_fill_edge  <= '0;
            s1_ghost_edge <= '0;
        end else begin
            s1_hcount     <= bus.hcount_in;
            s1_in_bar_x   <= h_in;
            s1_in_bar_y   <= v_in;
            s1_border     <= h_ring && v_ring && !(h_in && v_in);
            s1_flash      <= flash_on;
            s1_fill_edge  <= X_LO + (HCOUNT_W'(health) << PX_PER_HP_LOG2);
            s1_ghost_edge <= X_LO + (HCOUNT_W'(ghost) << PX_PER_HP_LOG2);
        end
    end

    // Stage 2: colour select.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pixel <= '0;
        end else if (s1_border) begin
            pixel <= WHITE;
        end else if (s1_in_bar_x && s1_in_bar_y) begin
            if (s1_hcount < s1_fill_edge)
                pixel <= s1_flash ? WHITE : FILL_COLOR;
            else if (s1_hcount < s1_ghost_edge)
                pixel <= DRAIN_RED;
            else
                pixel <= BAR_BG;
        end else begin
            pixel <= '0;
        end
    end

    assign bus.pixel_out  = pixel;
    assign bus.health_out = health;
    assign bus.dead_out   = dead;

endmodule

// File: tb/tb_health_bar_renderer.sv
module tb_health_bar_renderer;

    localparam int MAXH = 100;
    localparam int PX   = 2;
    localparam int BX   = 32;
    localparam int BY   = 24;
    localparam int BH   = 16;
    localparam int BW   = MAXH * PX;
    localparam int NFL  = 24;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    int m_health, m_ghost, m_since;
    bit m_hit, m_dead;

    health_bar_if bus();

    health_bar_renderer dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_health = MAXH; m_ghost = MAXH; m_since = 0; m_hit = 0; m_dead = 0;
    endtask

    function automatic bit flashing();
        int left;
        left = NFL - m_since;
        return m_hit && (m_since < NFL) && (((left / 4) % 2) == 1);
    endfunction

    function automatic logic [23:0] exp_px(input int h, input int v);
        int dx, dy;
        dx = h - BX;
        dy = v - BY;
        if (dx >= 0 && dx < BW && dy >= 0 && dy < BH) begin
            if (dx < m_health * PX) return flashing() ? 24'hFFFFFF : 24'h00C000;
            if (dx < m_ghost * PX)  return 24'hC00000;
            return 24'h202020;
        end
        if (dx >= -1 && dx <= BW && dy >= -1 && dy <= BH) return 24'hFFFFFF;
        return 24'h0;
    endfunction

    // One clock with the given strobes; called and returns at a negedge.
    task automatic step(input bit fr, input bit gr, input bit dv, input int amt);
        int old;
        bus.new_frame_in     = fr;
        bus.game_reset_in    = gr;
        bus.damage_valid_in  = dv;
        bus.damage_amount_in = 7'(amt);
        @(posedge clk);
        if (gr) begin
            model_reset();
        end else begin
            old = m_health;
            if (fr) begin
                m_ghost = (m_ghost > old) ? m_ghost - 1 : old;
                if (m_hit) begin
                    m_since++;
                    if (m_since >= NFL) m_hit = 0;
                end
            end
            if (dv && !m_dead) begin
                m_health = (amt >= old) ? 0 : old - amt;
                if (m_health == 0) begin
                    m_dead = 1; m_hit = 0;
                end else begin
                    m_hit = 1; m_since = 0;
                end
            end
        end
        @(negedge clk);
        bus.new_frame_in    = 1'b0;
        bus.game_reset_in   = 1'b0;
        bus.damage_valid_in = 1'b0;
    endtask

    task automatic check_px(input int h, input int v, input string tag);
        logic [23:0] e;
        bus.hcount_in = 11'(h);
        bus.vcount_in = 10'(v);
        e = exp_px(h, v);
        @(negedge clk);
        @(negedge clk);
        chk(tag, 32'(bus.pixel_out), 32'(e));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_health"}, 32'(bus.health_out), 32'(m_health));
        chk({tag, "_dead"}, 32'(bus.dead_out), 32'(m_dead));
    endtask

    // Streams n random coordinates around the bar, one per cycle.
    task automatic scan(input int n);
        logic [23:0] e[$];
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) chk("scan_px", 32'(bus.pixel_out), 32'(e.pop_front()));
            if (i < n) begin
                int h, v;
                h = int'($urandom_range(BX + BW + 2, BX - 3));
                v = int'($urandom_range(BY + BH + 2, BY - 3));
                bus.hcount_in = 11'(h);
                bus.vcount_in = 10'(v);
                e.push_back(exp_px(h, v));
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n                = 1'b0;
        bus.hcount_in        = '0;
        bus.vcount_in        = '0;
        bus.new_frame_in     = 1'b0;
        bus.game_reset_in    = 1'b0;
        bus.damage_valid_in  = 1'b0;
        bus.damage_amount_in = '0;
        model_reset();

        repeat (3) @(negedge clk);
        chk("rst_health", 32'(bus.health_out), 32'(MAXH));
        chk("rst_dead", 32'(bus.dead_out), 32'd0);
        chk("rst_pixel", 32'(bus.pixel_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-health geometry
        check_px(32, 24, "fill_left");
        check_px(231, 24, "fill_right");
        check_px(232, 24, "border_right");
        check_px(233, 24, "outside_right");
        check_px(31, 24, "border_left");
        check_px(100, 23, "border_top");
        check_px(100, 40, "border_bottom");
        check_px(100, 41, "outside_below");
        scan(60);

        // Damage 30: ghost trails then drains to health
        step(0, 0, 1, 30);
        check_state("dmg30");
        check_px(172, 30, "ghost_red");
        check_px(171, 30, "fill_edge");
        for (int f = 0; f < 30; f++) step(1, 0, 0, 0);
        chk("ghost_drained_model", 32'(m_ghost), 32'd70);
        check_px(172, 30, "ghost_gone");
        scan(40);

        // Damage 10: blink over the flash window
        step(0, 0, 1, 10);
        check_state("dmg10");
        check_px(33, 30, "flash_f0");
        for (int f = 1; f <= 26; f++) begin
            step(1, 0, 0, 0);
            check_px(33, 30, $sformatf("flash_f%0d", f));
        end
        check_px(33, 30, "steady_after_flash");

        // Random damage / frame mix
        for (int it = 0; it < 20; it++) begin
            step(($urandom % 2) == 1, 0, 1, int'($urandom_range(25, 0)));
            check_state("rnd_dmg");
            repeat (int'($urandom_range(6, 0))) step(1, 0, 0, 0);
            scan(30);
        end

        // Overkill and damage while dead
        step(0, 1, 0, 0);
        step(0, 0, 1, 50);
        check_state("hp50");
        step(0, 0, 1, 120);
        check_state("overkill");
        chk("dead_flag", 32'(bus.dead_out), 32'd1);
        check_px(33, 30, "dead_ghost");
        step(0, 0, 1, 5);
        check_state("dead_ignore");

        // Restart beats damage in the same cycle
        step(0, 1, 1, 40);
        check_state("reset_vs_dmg");
        check_px(33, 30, "reset_no_flash");

        // Async reset during HIT
        step(0, 0, 1, 7);
        check_state("pre_async");
        repeat (3) step(1, 0, 0, 0);
        bus.hcount_in = 11'd33;
        bus.vcount_in = 10'd30;
        #2 rst_n = 1'b0;
        #1;
        chk("async_health", 32'(bus.health_out), 32'(MAXH));
        chk("async_dead", 32'(bus.dead_out), 32'd0);
        chk("async_pixel", 32'(bus.pixel_out), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_px(32, 24, "post_async_fill");
        check_px(33, 30, "post_async_noflash");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
